expr_result_checker: RTL and testbench

- Sequential checker downstream of a combinational vloghammer expression block; consumes that block's 90-bit packed result y.
- Each accepted vector compares the DUT result against a golden result from a reference model, per field y0..y17.
- Accumulates a mismatch count, first-failure info, a sticky per-field error mask and a 32-bit MISR signature of the DUT results.
- Reports pass/fail after NUM_VEC vectors.

---
 rtl/expr_result_checker.sv | 227 ++++++++++++++++++++++
 tb/tb_expr_result_checker.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_result_checker.sv
// -----------------------------------------------------------------------------
// expr_result_checker
//
// Sequential checker placed after a combinational expression block. It compares
// the block's 90-bit packed result (dut_y) against a golden result (ref_y) one
// field at a time. Over a run of NUM_VEC accepted vectors it builds:
//   - a saturating mismatch count,
//   - the index and lowest field of the first mismatching vector,
//   - a sticky per-field error mask,
//   - a 32-bit MISR signature of dut_y.
// After the last vector it raises done, and raises pass if nothing mismatched.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   start            begin a run (honoured in IDLE or DONE only)
//   in_valid         dut_y / ref_y carry a vector this cycle
//   in_ready         checker accepts a vector this cycle (high in RUN)
//   dut_y, ref_y     packed results under test / golden
//   done             run complete (registered)
//   pass             done with zero mismatches (registered)
//   mismatch_count   number of mismatching vectors, saturating
//   first_fail_vec   index of the first mismatching vector
//   first_fail_field lowest mismatching field index in that vector
//   field_err_mask   sticky, bit k set if field yk ever mismatched
//   signature        MISR over dut_y
//
// Field layout, MSB first: widths 4,5,6 repeat six times, y0 = [89:86] down to
// y17 = [5:0]. Only Y_W = 90 is supported.
// -----------------------------------------------------------------------------
module expr_result_checker #(
  parameter int Y_W     = 90,
  parameter int NUM_VEC = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   dut_y,
  input  logic [Y_W-1:0]   ref_y,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] first_fail_vec,
  output logic [4:0]       first_fail_field,
  output logic [17:0]      field_err_mask,
  output logic [31:0]      signature
);

  localparam int NUM_FIELDS = 18;

  // The vector counter has to reach NUM_VEC-1 (up to 65535) even when the
  // reported counters are narrower, so it is never narrower than 16 bits.
  // first_fail_vec reports its low CNT_W bits.
  localparam int VEC_W = (CNT_W > 16) ? CNT_W : 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0]      MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0]      MISR_SEED = 32'hFFFF_FFFF;
  localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q,  state_d;
  logic [VEC_W-1:0]      vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]      mm_cnt_q, mm_cnt_d;
  logic [CNT_W-1:0]      ff_vec_q, ff_vec_d;
  logic [4:0]            ff_field_q, ff_field_d;
  logic [NUM_FIELDS-1:0] err_mask_q, err_mask_d;
  logic [31:0]           sig_q,    sig_d;
  logic                  done_q,   done_d;
  logic                  pass_q,   pass_d;

  // ---------------------------------------------------------------------------
  // Per-field compare
  // ---------------------------------------------------------------------------
  logic [NUM_FIELDS-1:0] field_err;
  logic                  any_err;
  logic [4:0]            lowest_err;

  // Field k sits in group k/3 (15 bits per group); its offset inside the group
  // is 0, 4 or 9 bits below the group MSB for widths 4, 5, 6.
  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    localparam int FW  = (k % 3 == 0) ? 4 : (k % 3 == 1) ? 5 : 6;
    localparam int OFS = 15 * (k / 3) + ((k % 3 == 0) ? 0 : (k % 3 == 1) ? 4 : 9);
    localparam int MSB = 89 - OFS;
    assign field_err[k] = |(dut_y[MSB -: FW] ^ ref_y[MSB -: FW]);
  end

  assign any_err = |field_err;

  // Scan from the top so the last hit, the lowest index, wins: y0 has priority.
  always_comb begin
    lowest_err = '0;
    for (int k = NUM_FIELDS - 1; k >= 0; k--) begin
      if (field_err[k]) lowest_err = 5'(k);
    end
  end

  // ---------------------------------------------------------------------------
  // MISR: shift left with CRC-32 feedback, then fold all 90 result bits in.
  // ---------------------------------------------------------------------------
  logic [31:0] fold;
  logic [31:0] sig_next;

  assign fold     = dut_y[31:0] ^ dut_y[63:32] ^ {6'b0, dut_y[89:64]};
  assign sig_next = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic accept;

  assign in_ready = (state_q == ST_RUN);
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold value first, so no path through the
  // case/if structure leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    vec_cnt_d  = vec_cnt_q;
    mm_cnt_d   = mm_cnt_q;
    ff_vec_d   = ff_vec_q;
    ff_field_d = ff_field_q;
    err_mask_d = err_mask_q;
    sig_d      = sig_q;
    done_d     = done_q;
    pass_d     = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Vectors offered here are ignored; only start does anything.
        if (start) begin
          state_d    = ST_RUN;
          vec_cnt_d  = '0;
          mm_cnt_d   = '0;
          ff_vec_d   = '0;
          ff_field_d = '0;
          err_mask_d = '0;
          sig_d      = MISR_SEED;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end

      ST_RUN: begin
        if (accept) begin
          vec_cnt_d = vec_cnt_q + 1'b1;
          sig_d     = sig_next;

          if (any_err) begin
            mm_cnt_d   = (mm_cnt_q == CNT_MAX) ? mm_cnt_q : mm_cnt_q + 1'b1;
            err_mask_d = err_mask_q | field_err;
            // The count saturates instead of wrapping, so zero means no
            // earlier mismatch in this run.
            if (mm_cnt_q == '0) begin
              ff_vec_d   = vec_cnt_q[CNT_W-1:0];
              ff_field_d = lowest_err;
            end
          end

          if (vec_cnt_q == LAST_VEC) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            // mm_cnt_d already includes the vector being accepted.
            pass_d  = (mm_cnt_d == '0);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before this edge, independent of statement order.
  // NOTE: the datapath registers are reset along with the FSM because every
  // output must read 0 after reset; none of this state is a memory array.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      vec_cnt_q  <= '0;
      mm_cnt_q   <= '0;
      ff_vec_q   <= '0;
      ff_field_q <= '0;
      err_mask_q <= '0;
      sig_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_cnt_q  <= vec_cnt_d;
      mm_cnt_q   <= mm_cnt_d;
      ff_vec_q   <= ff_vec_d;
      ff_field_q <= ff_field_d;
      err_mask_q <= err_mask_d;
      sig_q      <= sig_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_count   = mm_cnt_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_field = ff_field_q;
  assign field_err_mask   = err_mask_q;
  assign signature        = sig_q;

endmodule

// File: tb/tb_expr_result_checker.sv
// -----------------------------------------------------------------------------
// tb_expr_result_checker
//
// Three checker instances share one set of inputs:
//   dut_a : NUM_VEC=4,  CNT_W=16  main behaviour, tracked every cycle by a model
//   dut_s : NUM_VEC=20, CNT_W=4   mismatch-count saturation
//   dut_o : NUM_VEC=1,  CNT_W=16  single-vector runs driven from a vector table
// -----------------------------------------------------------------------------
module tb_expr_result_checker;

  localparam int A_NV = 4;
  localparam int S_NV = 20;
  localparam int S_CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [89:0] dut_y;
  logic [89:0] ref_y;

  logic a_in_ready, a_done, a_pass;
  logic [15:0] a_mm, a_ffv;
  logic [4:0]  a_fff;
  logic [17:0] a_mask;
  logic [31:0] a_sig;

  logic s_in_ready, s_done, s_pass;
  logic [S_CW-1:0] s_mm, s_ffv;
  logic [4:0]  s_fff;
  logic [17:0] s_mask;
  logic [31:0] s_sig;

  logic o_in_ready, o_done, o_pass;
  logic [15:0] o_mm, o_ffv;
  logic [4:0]  o_fff;
  logic [17:0] o_mask;
  logic [31:0] o_sig;

  expr_result_checker #(.Y_W(90), .NUM_VEC(A_NV), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(a_in_ready), .dut_y(dut_y), .ref_y(ref_y), .done(a_done),
    .pass(a_pass), .mismatch_count(a_mm), .first_fail_vec(a_ffv),
    .first_fail_field(a_fff), .field_err_mask(a_mask), .signature(a_sig));

  expr_result_checker #(.Y_W(90), .NUM_VEC(S_NV), .CNT_W(S_CW)) dut_s (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(s_in_ready), .dut_y(dut_y), .ref_y(ref_y), .done(s_done),
    .pass(s_pass), .mismatch_count(s_mm), .first_fail_vec(s_ffv),
    .first_fail_field(s_fff), .field_err_mask(s_mask), .signature(s_sig));

  expr_result_checker #(.Y_W(90), .NUM_VEC(1), .CNT_W(16)) dut_o (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(o_in_ready), .dut_y(dut_y), .ref_y(ref_y), .done(o_done),
    .pass(o_pass), .mismatch_count(o_mm), .first_fail_vec(o_ffv),
    .first_fail_field(o_fff), .field_err_mask(o_mask), .signature(o_sig));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model for dut_a, written from the field/run rules directly
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;

  mstate_t     m_state;
  int          m_cnt, m_mm, m_ffv, m_fff;
  bit          m_fail_seen;
  logic [17:0] m_mask;
  logic [31:0] m_sig;
  bit          m_done, m_pass;

  function automatic logic [17:0] m_field_errs(input logic [89:0] d, input logic [89:0] r);
    int          widths[3] = '{4, 5, 6};
    int          top = 90;
    logic [89:0] x = d ^ r;
    logic [17:0] e = '0;
    for (int k = 0; k < 18; k++) begin
      int w = widths[k % 3];
      for (int b = top - w; b < top; b++) if (x[b]) e[k] = 1'b1;
      top -= w;
    end
    return e;
  endfunction

  function automatic int m_lowest(input logic [17:0] e);
    for (int k = 0; k < 18; k++) if (e[k]) return k;
    return 0;
  endfunction

  function automatic logic [31:0] m_sig_next(input logic [31:0] s, input logic [89:0] d);
    logic [31:0] fold = d[31:0] ^ d[63:32] ^ {6'b0, d[89:64]};
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ fold;
  endfunction

  task automatic model_edge();
    logic [17:0] e;
    if (reset) begin
      m_state = M_IDLE; m_cnt = 0; m_mm = 0; m_ffv = 0; m_fff = 0;
      m_fail_seen = 0; m_mask = '0; m_sig = '0; m_done = 0; m_pass = 0;
    end else begin
      case (m_state)
        M_IDLE, M_DONE: if (start) begin
          m_state = M_RUN; m_cnt = 0; m_mm = 0; m_ffv = 0; m_fff = 0;
          m_fail_seen = 0; m_mask = '0; m_sig = 32'hFFFF_FFFF; m_done = 0; m_pass = 0;
        end
        M_RUN: if (in_valid) begin
          e = m_field_errs(dut_y, ref_y);
          if (e != 0) begin
            if (m_mm < 65535) m_mm++;
            m_mask |= e;
            if (!m_fail_seen) begin
              m_fail_seen = 1; m_ffv = m_cnt; m_fff = m_lowest(e);
            end
          end
          m_sig = m_sig_next(m_sig, dut_y);
          m_cnt++;
          if (m_cnt == A_NV) begin
            m_state = M_DONE; m_done = 1; m_pass = (m_mm == 0);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_ready"}, a_in_ready, m_state == M_RUN);
    check({tag, ".done"}, a_done, m_done);
    check({tag, ".pass"}, a_pass, m_pass);
    check({tag, ".mismatch_count"}, a_mm, m_mm);
    check({tag, ".first_fail_vec"}, a_ffv, m_ffv);
    check({tag, ".first_fail_field"}, a_fff, m_fff);
    check({tag, ".field_err_mask"}, a_mask, m_mask);
    check({tag, ".signature"}, a_sig, m_sig);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge, outputs
  // are read at that same point, well away from the next edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input logic [89:0] d, input logic [89:0] r);
    in_valid = v; dut_y = d; ref_y = r;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; in_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [89:0] rand90();
    logic [95:0] t = {$urandom, $urandom, $urandom};
    return t[89:0];
  endfunction

  // Single-vector records applied to dut_o
  typedef struct {
    logic [89:0] d;
    logic [89:0] r;
    bit          exp_pass;
    logic [4:0]  exp_field;
    logic [17:0] exp_mask;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [89:0] one;
    logic [89:0] d;
    logic [31:0] s;

    one = 90'd1;

    tbl[0] = '{d: rand90(), r: '0, exp_pass: 1, exp_field: 5'd0,  exp_mask: 18'h00000};
    tbl[1] = '{d: rand90(), r: '0, exp_pass: 0, exp_field: 5'd0,  exp_mask: 18'h00001};
    tbl[2] = '{d: rand90(), r: '0, exp_pass: 0, exp_field: 5'd1,  exp_mask: 18'h00002};
    tbl[3] = '{d: rand90(), r: '0, exp_pass: 0, exp_field: 5'd5,  exp_mask: 18'h00020};
    tbl[4] = '{d: rand90(), r: '0, exp_pass: 0, exp_field: 5'd6,  exp_mask: 18'h00040};
    tbl[5] = '{d: rand90(), r: '0, exp_pass: 0, exp_field: 5'd8,  exp_mask: 18'h00100};
    tbl[6] = '{d: rand90(), r: '0, exp_pass: 0, exp_field: 5'd16, exp_mask: 18'h10000};
    tbl[7] = '{d: rand90(), r: '0, exp_pass: 0, exp_field: 5'd17, exp_mask: 18'h20000};
    tbl[8] = '{d: rand90(), r: '0, exp_pass: 0, exp_field: 5'd0,  exp_mask: 18'h20001};
    tbl[9] = '{d: rand90(), r: '0, exp_pass: 0, exp_field: 5'd0,  exp_mask: 18'h3FFFF};
    tbl[0].r = tbl[0].d;
    tbl[1].r = tbl[1].d ^ (one << 86);            // y0 LSB
    tbl[2].r = tbl[2].d ^ (one << 85);            // y1 MSB
    tbl[3].r = tbl[3].d ^ (one << 60);            // y5 LSB
    tbl[4].r = tbl[4].d ^ (one << 59);            // y6 MSB
    tbl[5].r = tbl[5].d ^ (one << 45);            // y8 LSB
    tbl[6].r = tbl[6].d ^ (one << 6);             // y16 LSB
    tbl[7].r = tbl[7].d ^ (one << 5);             // y17 MSB
    tbl[8].r = tbl[8].d ^ (one << 89) ^ one;      // y0 and y17
    tbl[9].r = ~tbl[9].d;                         // every field

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; dut_y = '0; ref_y = '0;
    m_state = M_IDLE;

    // ---- reset state -------------------------------------------------------
    do_reset();
    check_all("reset");
    check("reset.sig_zero", a_sig, 32'h0);
    check("reset.in_ready_zero", a_in_ready, 1'b0);

    // ---- vectors in IDLE are ignored ---------------------------------------
    for (int i = 0; i < 3; i++) begin
      drive(1, rand90(), rand90());
      tick();
    end
    check_all("idle_ignore");
    check("idle_ignore.mm", a_mm, 16'd0);

    // ---- all-match run -----------------------------------------------------
    do_start();
    check("allmatch.seed", a_sig, 32'hFFFF_FFFF);
    check("allmatch.in_ready", a_in_ready, 1'b1);
    drive(1, '0, '0);
    for (int i = 0; i < 3; i++) tick();
    check("allmatch.done_early", a_done, 1'b0);
    tick();
    check("allmatch.done", a_done, 1'b1);
    check("allmatch.pass", a_pass, 1'b1);
    check("allmatch.mask", a_mask, 18'h0);
    s = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0);
    check("allmatch.sig", a_sig, s);
    check_all("allmatch");

    // ---- vectors in DONE are ignored ---------------------------------------
    for (int i = 0; i < 3; i++) begin
      drive(1, rand90(), rand90());
      tick();
    end
    check("done_ignore.pass", a_pass, 1'b1);
    check_all("done_ignore");

    // ---- single-field error in vector 2 ------------------------------------
    do_start();
    for (int i = 0; i < 4; i++) begin
      d = rand90();
      drive(1, d, (i == 2) ? (d ^ (one << 60)) : d);
      tick();
    end
    check("single.mm", a_mm, 16'd1);
    check("single.ffv", a_ffv, 16'd2);
    check("single.fff", a_fff, 5'd5);
    check("single.mask", a_mask, 18'h00020);
    check("single.pass", a_pass, 1'b0);
    check_all("single");

    // ---- restart from DONE, multi-field priority ---------------------------
    do_start();
    check("restart.mm", a_mm, 16'd0);
    check("restart.mask", a_mask, 18'h0);
    check("restart.sig", a_sig, 32'hFFFF_FFFF);
    check("restart.done", a_done, 1'b0);
    d = rand90();
    drive(1, d, d ^ (one << 89) ^ one);
    tick();
    check("prio.v0.fff", a_fff, 5'd0);
    check("prio.v0.mask", a_mask, 18'h20001);
    d = rand90();
    drive(1, d, d ^ (one << 71));
    tick();
    check("prio.v1.mm", a_mm, 16'd2);
    check("prio.v1.ffv", a_ffv, 16'd0);
    check("prio.v1.fff", a_fff, 5'd0);
    check("prio.v1.mask", a_mask, 18'h20009);
    for (int i = 0; i < 2; i++) begin
      d = rand90();
      drive(1, d, d);
      tick();
    end
    check("prio.pass", a_pass, 1'b0);
    check_all("prio");

    // ---- clean second run --------------------------------------------------
    do_start();
    for (int i = 0; i < 4; i++) begin
      d = rand90();
      drive(1, d, d);
      tick();
    end
    check("clean.pass", a_pass, 1'b1);
    check_all("clean");

    // ---- handshake gaps ----------------------------------------------------
    do_start();
    begin
      bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < 7; i++) begin
        d = rand90();
        drive(pat[i], d, ($urandom_range(0, 1) == 1) ? d : rand90());
        tick();
        if (i == 5) check("gaps.done_early", a_done, 1'b0);
      end
    end
    check("gaps.done", a_done, 1'b1);
    check("gaps.in_ready", a_in_ready, 1'b0);
    check_all("gaps");

    // ---- reset mid-run, reset beats start, fresh run -----------------------
    do_start();
    for (int i = 0; i < 2; i++) begin
      d = rand90();
      drive(1, d, d ^ (one << 30));
      tick();
    end
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check("midreset.in_ready", a_in_ready, 1'b0);
    check("midreset.mm", a_mm, 16'd0);
    check("midreset.sig", a_sig, 32'h0);
    check_all("midreset");
    do_start();
    for (int i = 0; i < 4; i++) begin
      d = rand90();
      drive(1, d, (i == 3) ? rand90() : d);
      tick();
    end
    check("fresh.done", a_done, 1'b1);
    check("fresh.ffv", a_ffv, 16'd3);
    check_all("fresh");

    // ---- single-vector table on dut_o --------------------------------------
    for (int i = 0; i < 10; i++) begin
      do_start();
      drive(1, tbl[i].d, tbl[i].r);
      tick();
      in_valid = 1'b0;
      check($sformatf("tbl%0d.done", i), o_done, 1'b1);
      check($sformatf("tbl%0d.pass", i), o_pass, tbl[i].exp_pass);
      check($sformatf("tbl%0d.mm", i), o_mm, tbl[i].exp_pass ? 16'd0 : 16'd1);
      check($sformatf("tbl%0d.ffv", i), o_ffv, 16'd0);
      check($sformatf("tbl%0d.fff", i), o_fff, tbl[i].exp_field);
      check($sformatf("tbl%0d.mask", i), o_mask, tbl[i].exp_mask);
      check($sformatf("tbl%0d.sig", i), o_sig, m_sig_next(32'hFFFF_FFFF, tbl[i].d));
    end

    // ---- saturation on dut_s -----------------------------------------------
    do_reset();
    do_start();
    for (int i = 0; i < S_NV; i++) begin
      d = rand90();
      drive(1, d, ~d);
      tick();
      if (i == S_NV - 2) check("sat.done_early", s_done, 1'b0);
    end
    in_valid = 1'b0;
    check("sat.done", s_done, 1'b1);
    check("sat.mm", s_mm, 4'hF);
    check("sat.pass", s_pass, 1'b0);
    check("sat.ffv", s_ffv, 4'h0);
    check("sat.fff", s_fff, 5'd0);
    check("sat.mask", s_mask, 18'h3FFFF);

    // ---- randomized traffic against the model ------------------------------
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int mode;
      d = rand90();
      mode = $urandom_range(0, 3);
      start = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 99) < 70, d,
            (mode < 2) ? d : (mode == 2) ? (d ^ (one << $urandom_range(0, 89))) : rand90());
      tick();
      check_all($sformatf("rand%0d", i));
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
